mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   Consumer end of the EX/MEM pipeline register in the 5-stage MIPS pipeline.
//   Performs the data-memory access over a req/ack handshake and stalls upstream while memory is busy.
//   Drives the MEM/WB pipeline register consumed by writeback.
//   Sits between the EX/MEM register and the WB mux/register file.
// PARAMETERS
//   DW  32  data/ALU word width
//   AW  32  data-memory address width (low AW bits of AluOut)
//   RW  5   destination register address width
// PORTS
//   clk           in   1   rising-edge clock
//   rst_n         in   1   async active-low reset
//   MemtoReg      in   1   EX/MEM: load, writeback from memory
//   RegWrite      in   1   EX/MEM: writes register file
//   MemWrite      in   1   EX/MEM: store
//   RegOut2       in   DW  EX/MEM: store data
//   AluOut        in   DW  EX/MEM: ALU result / memory address
//   Addr          in   RW  EX/MEM: destination register
//   dmem_req      out  1   memory request, held until ack
//   dmem_we       out  1   1 = write; equals MemWrite
//   dmem_addr     out  AW  equals AluOut[AW-1:0]
//   dmem_wdata    out  DW  equals RegOut2
//   dmem_rdata    in   DW  read data, valid in the ack cycle
//   dmem_ack      in   1   memory completion, single-cycle pulse
//   stall         out  1   hold EX/MEM and all earlier stages this cycle
//   wb_MemtoReg   out  1   MEM/WB: select memory data
//   wb_RegWrite   out  1   MEM/WB: register-file write enable
//   wb_ReadData   out  DW  MEM/WB: loaded data
//   wb_AluOut     out  DW  MEM/WB: ALU result
//   wb_Addr       out  RW  MEM/WB: destination register
//   stall_cnt     out  32  only with MEM_STALL_CNT_EN
// BEHAVIOUR
//   - Reset (rst_n=0, async): state IDLE; all wb_* = 0; stall_cnt = 0; dmem_req forced 0 while rst_n=0.
//   - mem_op = MemtoReg | MemWrite. If both MemtoReg and MemWrite are set, the op is a store and wb_MemtoReg is forced to 0.
//   - FSM IDLE:
//     - dmem_req = mem_op (combinational).
//     - mem_op & dmem_ack: zero-wait access, stall=0, stay IDLE.
//     - mem_op & !dmem_ack: stall=1, next WAIT.
//     - !mem_op: stall=0, ALU op passes through.
//   - FSM WAIT:
//     - dmem_req=1; stall = !dmem_ack.
//     - On dmem_ack, return to IDLE.
//   - dmem_addr/we/wdata stay stable throughout WAIT, because EX/MEM is held by stall.
//   - MEM/WB register update, every posedge:
//     - stall=0: load {MemtoReg', RegWrite, dmem_rdata (if ack, else 0), AluOut, Addr}.
//     - stall=1: load a bubble (wb_RegWrite=0, wb_MemtoReg=0, data fields 0), so no double writeback.
//   - Latency: ALU op 1 cycle; memory op 1 + N cycles, where N = ack wait cycles.
//   - dmem_ack while dmem_req=0 is ignored, with no state change.
//   - Bubble input (all controls 0) passes as a bubble.
//   - Reset mid-WAIT abandons the access. The memory side must tolerate the request dropping.
// CONFIGURATION
//   MEM_STALL_CNT_EN defined:
//     - stall_cnt increments by 1 on every cycle with stall=1.
//     - Wraps 32'hFFFFFFFF -> 0; cleared only by reset.
//   MEM_STALL_CNT_EN undefined:
//     - stall_cnt port absent; no counter logic.
// STRUCTURE
//   - pipe_defs.vh: state encodings (ST_IDLE=1'b0, ST_WAIT=1'b1), default widths DW/AW/RW.
//   - Sub-module memwb_reg: async-reset MEM/WB register with a bubble-insert input (driven by stall).
//   - FSM and handshake logic sit in mem_stage.
// TESTING
//   - ALU op: RegWrite=1, AluOut=0x1234, Addr=5 -> next cycle wb_RegWrite=1, wb_AluOut=0x1234, wb_Addr=5; dmem_req never 1.
//   - Zero-wait load: MemtoReg=1, AluOut=0x40, ack same cycle, rdata=0xDEADBEEF -> stall=0; next cycle wb_ReadData=0xDEADBEEF, wb_MemtoReg=1.
//   - 3-wait store: MemWrite=1, AluOut=0x80, RegOut2=0xA5 -> dmem_req/we high for 4 cycles with addr/wdata stable; stall=1 for 3 cycles; wb_RegWrite=0 throughout.
//   - Reset mid-WAIT: assert rst_n=0 in cycle 2 of a load -> dmem_req=0 immediately, wb_*=0, state IDLE after release.
//   - Spurious ack: dmem_ack=1 with no mem_op -> outputs reflect ALU path only; stall=0.
//   - MEM_STALL_CNT_EN: two loads with 2 and 5 wait cycles -> stall_cnt=7; preset near 32'hFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding and default bus widths.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 32;
  localparam int DEF_RW = 5;

endpackage

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register; a bubble request loads an all-zero entry instead of the inputs.
// Latency: 1 cycle. Backpressure: none, the register reloads on every clock edge.
module mem_stage_memwb_reg
  import mem_stage_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bubble,
  input  logic          mem_to_reg_d,
  input  logic          reg_write_d,
  input  logic [DW-1:0] read_data_d,
  input  logic [DW-1:0] alu_out_d,
  input  logic [RW-1:0] addr_d,
  output logic          mem_to_reg_q,
  output logic          reg_write_q,
  output logic [DW-1:0] read_data_q,
  output logic [DW-1:0] alu_out_q,
  output logic [RW-1:0] addr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble) begin
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      read_data_q  <= '0;
      alu_out_q    <= '0;
      addr_q       <= '0;
    end else begin
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      read_data_q  <= read_data_d;
      alu_out_q    <= alu_out_d;
      addr_q       <= addr_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access over req/ack, feeds the MEM/WB register. Optional stall counter: MEM_STALL_CNT_EN.
// Latency: ALU op 1 cycle, memory op 1 + ack-wait cycles.
// Backpressure: stall holds EX/MEM and earlier stages until dmem_ack; MEM/WB receives bubbles meanwhile.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int RW = DEF_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          MemtoReg,
  input  logic          RegWrite,
  input  logic          MemWrite,
  input  logic [DW-1:0] RegOut2,
  input  logic [DW-1:0] AluOut,
  input  logic [RW-1:0] Addr,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          stall,
  output logic          wb_MemtoReg,
  output logic          wb_RegWrite,
  output logic [DW-1:0] wb_ReadData,
  output logic [DW-1:0] wb_AluOut,
  output logic [RW-1:0] wb_Addr
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  state_t state;
  logic   mem_op;
  logic   ack_hit;

  assign mem_op     = MemtoReg | MemWrite;
  assign dmem_we    = MemWrite;
  assign dmem_addr  = AluOut[AW-1:0];
  assign dmem_wdata = RegOut2;

  // Request is dropped immediately on reset so a pending access is abandoned.
  assign dmem_req = rst_n & ((state == ST_WAIT) | mem_op);
  assign stall    = dmem_req & ~dmem_ack;
  assign ack_hit  = dmem_req & dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (mem_op && !dmem_ack) state <= ST_WAIT;
        ST_WAIT: if (dmem_ack) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A load+store combination is treated as a store: never select memory data for writeback.
  mem_stage_memwb_reg #(
    .DW (DW),
    .RW (RW)
  ) u_memwb (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (stall),
    .mem_to_reg_d (MemtoReg & ~MemWrite),
    .reg_write_d  (RegWrite),
    .read_data_d  (ack_hit ? dmem_rdata : '0),
    .alu_out_d    (AluOut),
    .addr_d       (Addr),
    .mem_to_reg_q (wb_MemtoReg),
    .reg_write_q  (wb_RegWrite),
    .read_data_q  (wb_ReadData),
    .alu_out_q    (wb_AluOut),
    .addr_q       (wb_Addr)
  );

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded random bench for mem_stage: the driver pushes per-cycle expectations, a negedge monitor checks them.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        MemtoReg, RegWrite, MemWrite;
  logic [31:0] RegOut2, AluOut;
  logic [4:0]  Addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        wb_MemtoReg, wb_RegWrite;
  logic [31:0] wb_ReadData, wb_AluOut;
  logic [4:0]  wb_Addr;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  mem_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .RegOut2     (RegOut2),
    .AluOut      (AluOut),
    .Addr        (Addr),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .stall       (stall),
    .wb_MemtoReg (wb_MemtoReg),
    .wb_RegWrite (wb_RegWrite),
    .wb_ReadData (wb_ReadData),
    .wb_AluOut   (wb_AluOut),
    .wb_Addr     (wb_Addr)
`ifdef MEM_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, req, we;
    logic [31:0] addr, wdata;
    logic        w_m2r, w_rw;
    logic [31:0] w_rd, w_alu;
    logic [4:0]  w_addr;
  } rec_t;

  rec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   stall_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction held in EX/MEM for n wait cycles plus the ack cycle.
  task automatic issue(input bit m2r, input bit rw, input bit mw, input logic [31:0] ro2,
                       input logic [31:0] alu, input logic [4:0] a, input int n,
                       input logic [31:0] rd);
    bit   mop;
    rec_t r;
    mop = m2r | mw;
    if (!mop) n = 0;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      MemtoReg = m2r; RegWrite = rw; MemWrite = mw;
      RegOut2 = ro2; AluOut = alu; Addr = a;
      if (mop) dmem_ack = (k == n);
      else     dmem_ack = 1'($urandom_range(0, 1));   // spurious acks must be ignored
      dmem_rdata = (mop && k == n) ? rd : $urandom;
      r.stall = mop && (k < n);
      r.req   = mop;
      r.we    = mw;
      r.addr  = alu;
      r.wdata = ro2;
      if (r.stall) begin
        r.w_m2r = 0; r.w_rw = 0; r.w_rd = 0; r.w_alu = 0; r.w_addr = 0;
      end else begin
        r.w_m2r  = m2r & ~mw;
        r.w_rw   = rw;
        r.w_rd   = mop ? rd : 32'd0;
        r.w_alu  = alu;
        r.w_addr = a;
      end
      exp_q.push_back(r);
    end
    if (mop) stall_total += n;
  endtask

  // Monitor: stall/dmem_* belong to the current cycle, wb_* to the previous one.
  initial begin
    rec_t cur, prev;
    bit   prev_vld;
    prev_vld = 0;
    forever begin
      @(negedge clk);
      if (prev_vld) begin
        chk("wb_MemtoReg", 32'(wb_MemtoReg), 32'(prev.w_m2r));
        chk("wb_RegWrite", 32'(wb_RegWrite), 32'(prev.w_rw));
        chk("wb_ReadData", wb_ReadData, prev.w_rd);
        chk("wb_AluOut", wb_AluOut, prev.w_alu);
        chk("wb_Addr", 32'(wb_Addr), 32'(prev.w_addr));
        prev_vld = 0;
      end
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("stall", 32'(stall), 32'(cur.stall));
        chk("dmem_req", 32'(dmem_req), 32'(cur.req));
        if (cur.req) begin
          chk("dmem_we", 32'(dmem_we), 32'(cur.we));
          chk("dmem_addr", dmem_addr, cur.addr);
          chk("dmem_wdata", dmem_wdata, cur.wdata);
        end
        prev = cur;
        prev_vld = 1;
      end
    end
  end

  task automatic idle_inputs();
    MemtoReg = 0; RegWrite = 0; MemWrite = 0;
    RegOut2 = 0; AluOut = 0; Addr = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    int kind;
    idle_inputs();
    rst_n = 1'b0;
    MemtoReg = 1;                           // request must stay low under reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst dmem_req", 32'(dmem_req), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst wb_RegWrite", 32'(wb_RegWrite), 0);
    chk("rst wb_MemtoReg", 32'(wb_MemtoReg), 0);
    chk("rst wb_AluOut", wb_AluOut, 0);
`ifdef MEM_STALL_CNT_EN
    chk("rst stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;

    // Reset in the second cycle of a load abandons it.
    @(posedge clk); #1;
    MemtoReg = 1; RegWrite = 1; AluOut = 32'h100; Addr = 5'd9;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("midwait stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("midwait dmem_req", 32'(dmem_req), 0);
    chk("midwait wb_RegWrite", 32'(wb_RegWrite), 0);
    chk("midwait wb_Addr", 32'(wb_Addr), 0);
    idle_inputs();
    RegWrite = 1; AluOut = 32'h55; Addr = 5'd3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    chk("post-rst stall", 32'(stall), 0);
    chk("post-rst dmem_req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    chk("post-rst wb_RegWrite", 32'(wb_RegWrite), 1);
    chk("post-rst wb_AluOut", wb_AluOut, 32'h55);
    idle_inputs();
    @(posedge clk);

    // Directed scoreboard cases, then random traffic.
    issue(0, 1, 0, 32'h0, 32'h1234, 5'd5, 0, 32'h0);            // ALU op
    issue(1, 1, 0, 32'h0, 32'h40, 5'd7, 0, 32'hDEADBEEF);       // zero-wait load
    issue(0, 0, 1, 32'hA5, 32'h80, 5'd0, 3, 32'h0);             // 3-wait store
    issue(1, 1, 0, 32'h0, 32'h44, 5'd2, 2, 32'h1111_2222);      // 2-wait load
    issue(1, 1, 0, 32'h0, 32'h48, 5'd4, 5, 32'h3333_4444);      // 5-wait load
    issue(1, 1, 1, 32'h77, 32'h4C, 5'd6, 1, 32'h5555_6666);     // load+store acts as store
    issue(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);               // bubble
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      issue(kind == 1 || kind == 3, 1'($urandom_range(0, 1)), kind >= 2,
            $urandom, $urandom, 5'($urandom), $urandom_range(0, 4), $urandom);
    end
    issue(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 0);
`ifdef MEM_STALL_CNT_EN
    chk("stall_cnt total", stall_cnt, 32'(stall_total));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
